// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe
//   Three-stage posit encoder: takes an unpacked value (sign, signed scale,
//   MSB-aligned fraction, zero/NaR flags) and produces the packed posit word,
//   rounded to nearest-even and saturated to maxpos/minpos.
//
//   Stage 1 (split): regime value k, run length/polarity, saturation flags.
//   Stage 2 (pack) : regime||exponent||fraction stream, round, clamp.
//   Stage 3 (sign) : two's complement for negatives, zero/NaR overrides.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_sign, in_zero,
//   in_nar                 sign, zero flag, NaR flag (NaR wins over zero)
//   in_scale [scale_w]     signed power-of-two exponent
//   in_frac  [frac_w]      fraction, MSB has weight 2^-1, hidden bit excluded
//   out_valid / out_ready  output handshake
//   out_posit [width]      encoded posit word
module posit_encode_pipe #(
    parameter int width   = 32,
    parameter int es      = 2,
    parameter int scale_w = 9,
    parameter int frac_w  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic               in_zero,
    input  logic               in_nar,
    input  logic [scale_w-1:0] in_scale,
    input  logic [frac_w-1:0]  in_frac,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   out_posit
);

    localparam int STAGES = 3;
    localparam int BODY_W = es + frac_w;              // exponent || fraction
    localparam int RW     = $clog2(width) + 1;        // regime run length
    localparam int N      = width + BODY_W + 1;       // room for longest stream
    localparam int KMAX   = width - 2;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              nar;
        logic              sat_max;
        logic              sat_min;
        logic              run_ones;   // k >= 0: run of ones, terminated by 0
        logic [RW-1:0]     run_len;
        logic [BODY_W-1:0] body;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic             nar;
        logic [width-2:0] mag;
    } s2_t;

    // ------------------------------------------------------------------
    // Handshake: a stage loads when empty or when it drains this cycle.
    // ------------------------------------------------------------------
    logic [STAGES:1] vld_pipe;
    logic            ld1, ld2, ld3;

    assign ld3       = !vld_pipe[3] || out_ready;
    assign ld2       = !vld_pipe[2] || ld3;
    assign ld1       = !vld_pipe[1] || ld2;
    assign in_ready  = ld1;
    assign out_valid = vld_pipe[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= in_valid;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: split scale into regime k and exponent bits
    // ------------------------------------------------------------------
    logic signed [scale_w-1:0] k;
    logic [BODY_W-1:0]         body_d;
    s1_t                       s1_d, s1_q;
    int                        kk;

    assign k = $signed(in_scale) >>> es;

    if (es > 0) begin : g_es
        assign body_d = {in_scale[es-1:0], in_frac};
    end else begin : g_no_es
        assign body_d = in_frac;
    end

    always_comb begin
        s1_d          = '0;
        kk            = int'(k);
        s1_d.sign     = in_sign;
        s1_d.zero     = in_zero;
        s1_d.nar      = in_nar;
        s1_d.sat_max  = kk >= KMAX;
        s1_d.sat_min  = kk < -KMAX;
        s1_d.run_ones = kk >= 0;
        s1_d.body     = body_d;
        // Saturated words get their magnitude forced in stage 2, so the run
        // length only has to be meaningful inside the representable range.
        if (!s1_d.sat_max && !s1_d.sat_min)
            s1_d.run_len = s1_d.run_ones ? RW'(kk + 1) : RW'(-kk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                s1_q <= '0;
        else if (ld1 && in_valid)  s1_q <= s1_d;
    end

    // ------------------------------------------------------------------
    // Stage 2: build stream, round to nearest-even, clamp
    // ------------------------------------------------------------------
    logic [N-1:0]     seed, strm;
    logic [width-2:0] mag;
    logic             guard, sticky, rnd;
    logic [width-1:0] sum;
    s2_t              s2_d, s2_q;

    always_comb begin
        // Terminator bit sits right above the body; shifting by the run
        // length leaves exactly run_len vacated bits for the regime run.
        seed   = {~s1_q.run_ones, s1_q.body, {width{1'b0}}};
        strm   = (seed >> s1_q.run_len)
               | (s1_q.run_ones ? ~({N{1'b1}} >> s1_q.run_len) : '0);
        mag    = strm[N-1 -: width-1];
        guard  = strm[N-width];
        sticky = |strm[N-width-1:0];
        rnd    = guard && (sticky || mag[0]);
        sum    = {1'b0, mag} + {{(width-1){1'b0}}, rnd};

        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.nar  = s1_q.nar;
        if (s1_q.sat_max)
            s2_d.mag = '1;
        else if (s1_q.sat_min)
            s2_d.mag = {{(width-2){1'b0}}, 1'b1};
        else if (sum[width-1])              // carry would hit the sign bit
            s2_d.mag = '1;
        else if (sum[width-2:0] == '0)      // never round a nonzero to zero
            s2_d.mag = {{(width-2){1'b0}}, 1'b1};
        else
            s2_d.mag = sum[width-2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   s2_q <= '0;
        else if (ld2 && vld_pipe[1])  s2_q <= s2_d;
    end

    // ------------------------------------------------------------------
    // Stage 3: sign and specials
    // ------------------------------------------------------------------
    logic [width-1:0] posit_d;

    always_comb begin
        posit_d = {1'b0, s2_q.mag};
        if (s2_q.nar)
            posit_d = {1'b1, {(width-1){1'b0}}};
        else if (s2_q.zero)
            posit_d = '0;
        else if (s2_q.sign)
            posit_d = -{1'b0, s2_q.mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   out_posit <= '0;
        else if (ld3 && vld_pipe[2])  out_posit <= posit_d;
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed bench for posit_encode_pipe (width=32, es=2).
module tb_posit_encode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        in_sign, in_zero, in_nar;
    logic [8:0]  in_scale;
    logic [31:0] in_frac;
    logic        out_valid, out_ready;
    logic [31:0] out_posit;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [8:0]  scale;
        logic [31:0] frac;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    posit_encode_pipe #(.width(32), .es(2), .scale_w(9), .frac_w(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_sign = 0; in_zero = 0; in_nar = 0;
        in_scale = '0; in_frac = '0; out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_posit !== 32'h0) begin
            bad++;
            $display("FAIL reset_state valid=%b posit=%h want valid=0 posit=00000000", out_valid, out_posit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        vec_t v[$];
        int   n;
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd0,   32'h0,        32'h40000000});
        v.push_back('{1'b1, 1'b0, 1'b0, 9'd0,   32'h0,        32'hC0000000});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd1,   32'h0,        32'h48000000});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'h1FF, 32'h0,        32'h38000000});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd0,   32'h80000000, 32'h44000000});
        n = v.size();
        for (int t = 0; t <= n + 3; t++) begin
            @(negedge clk);
            in_valid = (t < n); out_ready = 1'b1;
            if (t < n) begin
                in_sign = v[t].sign; in_zero = v[t].zero; in_nar = v[t].nar;
                in_scale = v[t].scale; in_frac = v[t].frac;
            end
            #1;
            if (t < n) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL basic_ready[%0d] in_ready=%b want 1", t, in_ready);
                end
            end
            total++;
            if (t >= 3 && t - 3 < n) begin
                if (out_valid !== 1'b1 || out_posit !== v[t-3].exp) begin
                    bad++;
                    $display("FAIL basic[%0d] valid=%b posit=%h want valid=1 posit=%h", t - 3, out_valid, out_posit, v[t-3].exp);
                end
            end else if (out_valid !== 1'b0) begin
                bad++; $display("FAIL basic_latency t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
    endtask

    task automatic test_rounding();
        vec_t v[$];
        int   n;
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd0, 32'h00000010, 32'h40000000});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd0, 32'h00000030, 32'h40000002});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd0, 32'h00000018, 32'h40000001});
        n = v.size();
        for (int t = 0; t <= n + 3; t++) begin
            @(negedge clk);
            in_valid = (t < n); out_ready = 1'b1;
            if (t < n) begin
                in_sign = v[t].sign; in_zero = v[t].zero; in_nar = v[t].nar;
                in_scale = v[t].scale; in_frac = v[t].frac;
            end
            #1;
            total++;
            if (t >= 3 && t - 3 < n) begin
                if (out_valid !== 1'b1 || out_posit !== v[t-3].exp) begin
                    bad++;
                    $display("FAIL round[%0d] valid=%b posit=%h want valid=1 posit=%h", t - 3, out_valid, out_posit, v[t-3].exp);
                end
            end else if (out_valid !== 1'b0) begin
                bad++; $display("FAIL round_latency t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
    endtask

    task automatic test_saturation();
        vec_t v[$];
        int   n;
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd200, 32'h0,        32'h7FFFFFFF});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'h138, 32'h0,        32'h00000001});  // -200
        v.push_back('{1'b1, 1'b0, 1'b0, 9'h138, 32'h0,        32'hFFFFFFFF});
        // k=29, e=3: guard and sticky set, rounds up onto maxpos, not NaR
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd119, 32'hFFFFFFFF, 32'h7FFFFFFF});
        v.push_back('{1'b0, 1'b0, 1'b0, 9'd120, 32'h0,        32'h7FFFFFFF});  // k=30
        v.push_back('{1'b0, 1'b0, 1'b0, 9'h188, 32'h0,        32'h00000001});  // -120, k=-30
        v.push_back('{1'b0, 1'b0, 1'b0, 9'h184, 32'h0,        32'h00000001});  // -124, k=-31
        n = v.size();
        for (int t = 0; t <= n + 3; t++) begin
            @(negedge clk);
            in_valid = (t < n); out_ready = 1'b1;
            if (t < n) begin
                in_sign = v[t].sign; in_zero = v[t].zero; in_nar = v[t].nar;
                in_scale = v[t].scale; in_frac = v[t].frac;
            end
            #1;
            total++;
            if (t >= 3 && t - 3 < n) begin
                if (out_valid !== 1'b1 || out_posit !== v[t-3].exp) begin
                    bad++;
                    $display("FAIL sat[%0d] valid=%b posit=%h want valid=1 posit=%h", t - 3, out_valid, out_posit, v[t-3].exp);
                end
            end else if (out_valid !== 1'b0) begin
                bad++; $display("FAIL sat_latency t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
    endtask

    task automatic test_specials();
        vec_t v[$];
        int   n;
        v.push_back('{1'b1, 1'b0, 1'b1, 9'd5,   32'h12345678, 32'h80000000});
        v.push_back('{1'b1, 1'b1, 1'b0, 9'd3,   32'hABCDEF01, 32'h00000000});
        v.push_back('{1'b0, 1'b1, 1'b1, 9'd0,   32'h0,        32'h80000000});
        v.push_back('{1'b0, 1'b1, 1'b0, 9'd200, 32'h0,        32'h00000000});
        n = v.size();
        for (int t = 0; t <= n + 3; t++) begin
            @(negedge clk);
            in_valid = (t < n); out_ready = 1'b1;
            if (t < n) begin
                in_sign = v[t].sign; in_zero = v[t].zero; in_nar = v[t].nar;
                in_scale = v[t].scale; in_frac = v[t].frac;
            end
            #1;
            total++;
            if (t >= 3 && t - 3 < n) begin
                if (out_valid !== 1'b1 || out_posit !== v[t-3].exp) begin
                    bad++;
                    $display("FAIL special[%0d] valid=%b posit=%h want valid=1 posit=%h", t - 3, out_valid, out_posit, v[t-3].exp);
                end
            end else if (out_valid !== 1'b0) begin
                bad++; $display("FAIL special_latency t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
        in_zero = 0; in_nar = 0; in_sign = 0;
    endtask

    // Words i = 0..9: scale 0, frac = i<<8 -> posit 0x40000000 | (i<<3).
    task automatic test_back_to_back();
        int          sent = 0, rcv = 0, occ = 0;
        logic        stalled = 0, saw_full = 0, acc, emit;
        logic [31:0] prev = '0, want;
        for (int c = 0; c < 200 && rcv < 10; c++) begin
            @(negedge clk);
            in_valid = (sent < 10);
            in_sign = 0; in_zero = 0; in_nar = 0; in_scale = '0;
            in_frac = 32'(sent) << 8;
            out_ready = (c % 3 == 0);
            #1;
            total++;
            if (in_ready !== !(occ == 3 && !out_ready)) begin
                bad++;
                $display("FAIL bp_in_ready c=%0d in_ready=%b want %b occ=%0d", c, in_ready, !(occ == 3 && !out_ready), occ);
            end
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_posit !== prev) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d valid=%b posit=%h want valid=1 posit=%h", c, out_valid, out_posit, prev);
                end
            end
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                want = 32'h40000000 | (32'(rcv) << 3);
                total++;
                if (out_posit !== want) begin
                    bad++; $display("FAIL bp_order[%0d] posit=%h want %h", rcv, out_posit, want);
                end
                rcv++;
            end
            if (!in_ready) saw_full = 1;
            stalled = out_valid && !out_ready;
            prev    = out_posit;
            occ     = occ + int'(acc) - int'(emit);
            if (acc) sent++;
        end
        total++;
        if (rcv != 10 || sent != 10) begin
            bad++; $display("FAIL bp_count rcv=%0d sent=%0d want 10/10", rcv, sent);
        end
        total++;
        if (saw_full !== 1'b1) begin
            bad++; $display("FAIL bp_full in_ready never low, want a full-pipe stall");
        end
        in_valid = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drain out_valid=%b want 0 (duplicate word)", out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_valid = (t < 2); out_ready = 1'b0;
            in_sign = 0; in_zero = 0; in_nar = 0; in_frac = '0;
            in_scale = (t == 0) ? 9'd1 : 9'd0;
        end
        #1;
        total++;
        if (out_valid !== 1'b1 || out_posit !== 32'h48000000) begin
            bad++; $display("FAIL rst_pre valid=%b posit=%h want 1/48000000", out_valid, out_posit);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_posit !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid valid=%b posit=%h in_ready=%b want 0/00000000/1", out_valid, out_posit, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_valid = 0;
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rst_idle t=%0d out_valid=%b want 0", t, out_valid);
            end
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_valid = (t == 0); in_scale = 9'h1FF; in_frac = '0;
            #1;
            total++;
            if (t < 3 && out_valid !== 1'b0) begin
                bad++; $display("FAIL rst_new_latency t=%0d out_valid=%b want 0", t, out_valid);
            end else if (t == 3 && (out_valid !== 1'b1 || out_posit !== 32'h38000000)) begin
                bad++; $display("FAIL rst_new valid=%b posit=%h want 1/38000000", out_valid, out_posit);
            end
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_specials();
        test_back_to_back();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
